// File: rtl/pwm_symbol_sequencer.sv
// Arms on a rising crossing of ref_in, clears the decoder, opens a fixed count window,
// captures the decoded symbol onto a valid/ready port, then waits out a quiet guard.
module pwm_symbol_sequencer #(
  parameter int DATA_W    = 16,
  parameter int SYM_W     = 8,
  parameter int WIN_LEN   = 256,
  parameter int DEC_LAT   = 2,
  parameter int GUARD_LEN = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start_en,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic signed [DATA_W-1:0] ref_in,
  input  logic [SYM_W-1:0]         decoded_symbol,
  output logic                     dec_clear,
  output logic                     enable_counter,
  output logic [SYM_W-1:0]         sym_data,
  output logic                     sym_valid,
  input  logic                     sym_ready,
  output logic                     overrun,
  output logic [15:0]              sym_count,
  output logic                     busy
);

  // One counter serves window, settle and guard phases, so size it for the longest.
  localparam int L1      = (WIN_LEN > GUARD_LEN) ? WIN_LEN : GUARD_LEN;
  localparam int MAX_LEN = (L1 > DEC_LAT) ? L1 : DEC_LAT;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WINDOW, S_SETTLE, S_CAPTURE, S_GUARD
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc;
  logic               prev_above, above, rise, capture;

  always_comb begin
    above    = data_in > ref_in;
    rise     = !prev_above && above;
    cnt_inc  = cnt + 1'b1;
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      S_IDLE:   if (start_en && rise) state_nx = S_CLEAR;
      S_CLEAR: begin
        state_nx = S_WINDOW;
        cnt_nx   = '0;
      end
      S_WINDOW: begin
        cnt_nx = cnt_inc;
        if (cnt_inc == CNT_W'(WIN_LEN)) begin
          cnt_nx   = '0;
          state_nx = (DEC_LAT == 0) ? S_CAPTURE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_nx = cnt_inc;
        if (cnt_inc == CNT_W'(DEC_LAT)) begin
          cnt_nx   = '0;
          state_nx = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        capture  = 1'b1;
        state_nx = S_GUARD;
        cnt_nx   = '0;
      end
      S_GUARD: begin
        // Any sample above the reference restarts the quiet run.
        if (above) cnt_nx = '0;
        else begin
          cnt_nx = cnt_inc;
          if (cnt_inc == CNT_W'(GUARD_LEN)) state_nx = S_IDLE;
        end
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      prev_above     <= 1'b0;
      dec_clear      <= 1'b0;
      enable_counter <= 1'b0;
      busy           <= 1'b0;
      sym_data       <= '0;
      sym_valid      <= 1'b0;
      overrun        <= 1'b0;
      sym_count      <= '0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      prev_above     <= above;
      dec_clear      <= (state_nx == S_CLEAR);
      enable_counter <= (state_nx == S_WINDOW);
      busy           <= (state_nx != S_IDLE);
      overrun        <= 1'b0;
      if (capture) begin
        sym_data  <= decoded_symbol;
        sym_valid <= 1'b1;
        overrun   <= sym_valid && !sym_ready;
        sym_count <= sym_count + 16'd1;
      end else if (sym_valid && sym_ready) begin
        sym_valid <= 1'b0;
      end
    end
  end

endmodule
